// File: rtl/mem_pkg.sv
// Shared constants and types for the four-bank word-interleaved memory responder.
// Byte address layout: [0] must be zero, [2:1] bank, [15:3] row.
package mem_pkg;
  localparam int NUM_BANKS   = 4;
  localparam int RD_LATENCY  = 2;
  localparam int BUSY_CYCLES = 4;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int BANK_LSB    = 1;
  localparam int BANK_W      = 2;
  localparam int ROW_LSB     = 3;
  localparam int ROW_W       = 13;
  localparam int CNT_W       = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ROW_W-1:0]  row_t;
endpackage

// File: rtl/mem_bank.sv
// One memory bank: word array, write port, registered read (pipe stage 1)
// and the occupancy counter that drives the requester stall.
module mem_bank
  import mem_pkg::*;
#(
  parameter int WORDS       = 8192,
  parameter int BUSY_CYCLES = mem_pkg::BUSY_CYCLES
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_acc,
  input  logic  i_wr,
  input  row_t  i_row,
  input  word_t i_wdata,
  output logic  o_rd_valid,
  output word_t o_rd_data,
  output logic  o_busy
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

  word_t            r_mem [WORDS];
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1_valid;
  word_t            r_s1_data;
  logic             w_rd_acc;

  assign w_rd_acc = i_acc & ~i_wr;

  // Array has no reset; the write is suppressed on an edge where reset is sampled.
  always_ff @(posedge clk) begin
    if (rst && i_acc && i_wr) begin
      r_mem[i_row] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      if (i_acc) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_s1_valid <= w_rd_acc;
      // Zero when idle so the top can OR the four stage-1 words together.
      r_s1_data  <= w_rd_acc ? r_mem[i_row] : '0;
    end
  end

  assign o_rd_valid = r_s1_valid;
  assign o_rd_data  = r_s1_data;
  assign o_busy     = (r_cnt != '0);
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved memory responder: bank decode, stall/err generation,
// stage-2 read register and output mux. Stall is a retry protocol; nothing is queued.
module banked_mem_responder
  import mem_pkg::*;
#(
  parameter int WORDS_PER_BANK = 8192,
  parameter int BUSY_CYCLES    = mem_pkg::BUSY_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic        stall,
  output logic [15:0] data_out,
  output logic        rd_valid,
  output logic [3:0]  busy,
  output logic        err
);
  logic                 w_req;
  logic                 w_err;
  logic                 w_stall;
  logic                 w_acc;
  logic [BANK_W-1:0]    w_bank;
  row_t                 w_row;
  logic [NUM_BANKS-1:0] w_busy;
  logic [NUM_BANKS-1:0] w_s1_valid;
  word_t                w_s1_data [NUM_BANKS];
  word_t                w_s1_merged;
  logic                 r_s2_valid;
  word_t                r_s2_data;

  assign w_bank  = addr[BANK_LSB +: BANK_W];
  assign w_row   = addr[ROW_LSB +: ROW_W];
  assign w_req   = rd | wr;
  assign w_err   = w_req & ((rd & wr) | addr[0]);
  assign w_stall = w_req & ~w_err & w_busy[w_bank];
  assign w_acc   = w_req & ~w_err & ~w_stall;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .WORDS       (WORDS_PER_BANK),
      .BUSY_CYCLES (BUSY_CYCLES)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_acc      (w_acc && (w_bank == BANK_W'(b))),
      .i_wr       (wr),
      .i_row      (w_row),
      .i_wdata    (data_in),
      .o_rd_valid (w_s1_valid[b]),
      .o_rd_data  (w_s1_data[b]),
      .o_busy     (w_busy[b])
    );
  end

  // At most one bank holds a stage-1 read per cycle; idle banks present zero.
  always_comb begin
    w_s1_merged = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_s1_merged = w_s1_merged | w_s1_data[b];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= |w_s1_valid;
      r_s2_data  <= w_s1_merged;
    end
  end

  assign stall    = w_stall;
  assign err      = w_err;
  assign busy     = w_busy;
  assign rd_valid = r_s2_valid;
  assign data_out = r_s2_data;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder: driver tasks issue requests and push
// expected read data (with due cycle) to a queue; a negedge monitor pops and compares.
module tb_banked_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        stall;
  logic [15:0] data_out;
  logic        rd_valid;
  logic [3:0]  busy;
  logic        err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  banked_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .stall    (stall),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .busy     (busy),
    .err      (err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every read result must match the head of the expected queue, on its due cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rd_valid: got data %h required no rd_valid", data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data", {16'h0, data_out}, {16'h0, mon_e[15:0]});
          check("rd_cycle", 32'(cyc), {16'h0, mon_e[31:16]});
        end
      end else begin
        check("idle_data_out", {16'h0, data_out}, 32'h0);
      end
    end
  end

  // Driver: present a request, retry while stalled, push expected read on accept
  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input bit push, input logic [15:0] exp_d, output int stalls);
    rd = r; wr = w; addr = a; data_in = d;
    stalls = 0;
    @(negedge clk);
    while (stall === 1'b1 && stalls < 10) begin
      stalls++;
      @(negedge clk);
    end
    if (stall === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_timeout: got stall after %0d cycles required accept", stalls);
    end
    if (push && r) exp_q.push_back({cyc[15:0] + 16'd2, exp_d});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int total;
    logic [15:0] line_a [4];
    logic [15:0] line_d [4];
    line_a[0] = 16'h0100; line_a[1] = 16'h0102; line_a[2] = 16'h0104; line_a[3] = 16'h0106;
    line_d[0] = 16'h1111; line_d[1] = 16'h2222; line_d[2] = 16'h3333; line_d[3] = 16'h4444;

    // Reset, then idle
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", {28'h0, busy}, 32'h0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_data_out", {16'h0, data_out}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Write then read back after the bank frees up
    req(1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 16'h0, st);
    check("wr_0010_stalls", 32'(st), 32'd0);
    idle(3);
    req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 16'hA5A5, st);
    check("rd_0010_stalls", 32'(st), 32'd0);
    idle(4);

    // Preload a line, then fill it on consecutive cycles
    total = 0;
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 1'b1, line_a[i], line_d[i], 1'b0, 16'h0, st);
      total += st;
    end
    check("preload_stalls", 32'(total), 32'd0);
    idle(3);
    total = 0;
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, line_a[i], 16'h0, 1'b1, line_d[i], st);
      total += st;
    end
    check("line_fill_stalls", 32'(total), 32'd0);
    idle(4);

    // Same-bank pair: read 0x0008 then write 0x0010 held while stalled
    req(1'b0, 1'b1, 16'h0008, 16'h0808, 1'b0, 16'h0, st);
    idle(3);
    req(1'b0, 1'b1, 16'h0020, 16'h2020, 1'b0, 16'h0, st);
    idle(3);
    req(1'b1, 1'b0, 16'h0008, 16'h0, 1'b1, 16'h0808, st);
    check("rd_0008_stalls", 32'(st), 32'd0);
    rd = 1'b0; wr = 1'b1; addr = 16'h0010; data_in = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pair_stall", {31'h0, stall}, 32'h1);
      check("pair_busy", {28'h0, busy}, 32'h1);
    end
    @(negedge clk);
    check("pair_accept_stall", {31'h0, stall}, 32'h0);
    check("pair_accept_busy", {28'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    idle(4);
    req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 16'hBEEF, st);
    check("rd_0010_new_stalls", 32'(st), 32'd0);
    idle(4);

    // Illegal requests: rd&wr, then misaligned read
    rd = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'hDEAD;
    @(negedge clk);
    check("rdwr_err", {31'h0, err}, 32'h1);
    check("rdwr_stall", {31'h0, stall}, 32'h0);
    check("rdwr_busy", {28'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    rd = 1'b1; wr = 1'b0; addr = 16'h0021; data_in = 16'h0;
    @(negedge clk);
    check("odd_err", {31'h0, err}, 32'h1);
    check("odd_stall", {31'h0, stall}, 32'h0);
    check("odd_busy", {28'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    idle(1);
    req(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 16'h2020, st);
    check("rd_0020_stalls", 32'(st), 32'd0);
    // Misaligned request to a busy bank errors rather than stalls
    rd = 1'b1; wr = 1'b0; addr = 16'h0021;
    @(negedge clk);
    check("odd_busy_bank_err", {31'h0, err}, 32'h1);
    check("odd_busy_bank_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    idle(4);

    // Reset one cycle after a read accept; a write on the reset edge is dropped
    req(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 16'h0, st);
    rst = 1'b0; rd = 1'b0; wr = 1'b1; addr = 16'h0102; data_in = 16'h9999;
    @(posedge clk);
    #1;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    @(negedge clk);
    check("post_rst_busy", {28'h0, busy}, 32'h0);
    check("post_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    @(posedge clk);
    #1;
    idle(4);
    req(1'b1, 1'b0, 16'h0102, 16'h0, 1'b1, 16'h2222, st);
    check("rd_0102_stalls", 32'(st), 32'd0);
    idle(5);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/banked_mem_responder.md
# banked_mem_responder

Four-bank, word-interleaved main-memory responder: the memory end of the cache controller's line-fill and write-back traffic. It accepts one read or write per cycle from the cache FSM and stalls the requester when the addressed bank is still busy. Accepted reads return data on a fixed two-cycle pipelined schedule, so a four-word line fill issued on consecutive cycles completes in six cycles.

## Interface
- `WORDS_PER_BANK`, default 8192: 16-bit words per bank; 4 banks × 8192 words = 64 KiB.
- `BUSY_CYCLES`, default 4: cycles a bank stays occupied, counting the accept cycle.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `rd` in 1: read request.
- `wr` in 1: write request.
- `addr` in 16: byte address, word aligned. `addr[2:1]` selects the bank; `addr[15:3]` is the row.
- `data_in` in 16: write data, sampled on the accept edge.
- `stall` out 1: request not accepted this cycle; requester holds `rd`/`wr`/`addr`/`data_in`.
- `data_out` out 16: read data, valid when `rd_valid` is 1.
- `rd_valid` out 1: `data_out` carries the read accepted two cycles earlier.
- `busy` out 4: per-bank occupied flags, for debug/perf.
- `err` out 1: illegal request this cycle.

## Operation
- Request is `req = rd | wr`.
- `err = req & ((rd & wr) | addr[0])`. An erroring request is never accepted, never stalls, and has no side effects.
- `stall = req & ~err & busy[addr[2:1]]`. It is combinational from inputs and current busy state.
- Accept condition: `acc = req & ~err & ~stall`.
- Write accept: the word at row `addr[15:3]` of bank `addr[2:1]` is written on the accept edge.
- Read accept: the word is captured into pipe stage 1 on the accept edge, then moved to stage 2. The stage-2 register drives `data_out`/`rd_valid`.
- Per-bank busy counter (2 bits):
  - Loaded with `BUSY_CYCLES-1` on accept.
  - Decrements to 0 otherwise.
  - `busy[b] = (cnt[b] != 0)`.
- Rows are stored as 13-bit indices; there is no wrap or aliasing inside the 64 KiB space.
- Memory array contents are not cleared by reset.
- Reset values while `rst` = 0 on an edge:
  - busy counters 0, so `busy` = 4'b0000.
  - Both pipe valids 0, so `rd_valid` = 0 and `data_out` = 16'h0000.
  - `stall` = 0 and `err` = 0 once inputs are idle.
- Reset mid-operation: in-flight reads are discarded and no `rd_valid` appears after reset. A write accepted on the same edge that reset is sampled is not performed.
- When `rd_valid` is 0, `data_out` holds 16'h0000. It is never stale data.

## Timing
- Read latency: accept in cycle N, then `rd_valid`/`data_out` in cycle N+2 for exactly one cycle.
- Throughput: one accept per cycle when consecutive requests hit different banks. A sequential line fill (offsets 0,2,4,6) is accepted in cycles N..N+3 and data arrives in N+2..N+5.
- Same-bank back-to-back: with accept at N, `stall` is asserted in N+1..N+3 and the next accept is at N+4.
- Stall is a retry protocol: the responder queues nothing and the requester re-presents the request each cycle.
- Write-then-read of the same address: the read is necessarily ≥4 cycles later (same bank) and returns the new data.
- Read and write requested in the same cycle (`rd & wr`): `err` = 1, nothing accepted, pipeline unaffected.

## Structure
- Package `mem_pkg`: `NUM_BANKS`=4, `RD_LATENCY`=2, `BUSY_CYCLES`, bank-select and row field positions.
- Sub-module `mem_bank`: one bank's word array, write port, registered read, and busy counter. The top instantiates it four times.
- The top holds bank decode, stall/err logic, the stage-2 pipe register, and the output mux.

## Test plan
- Reset, then idle: `busy`=0, `rd_valid`=0, `data_out`=0, `stall`=0, `err`=0.
- Write 16'hA5A5 @0x0010, wait 4 cycles, read @0x0010 → `rd_valid` two cycles after accept, `data_out`=16'hA5A5.
- Line fill: reads @0x0100, 0x0102, 0x0104, 0x0106 on consecutive cycles, all preloaded → zero stalls; data arrives on four consecutive cycles in order, the first two cycles after the first accept.
- Same-bank pair: read @0x0008, then write @0x0010 (both bank 0) held asserted → `stall`=1 for 3 cycles, write accepted on the 4th; `busy[0]` tracks this.
- Illegal: `rd`=`wr`=1 @0x0020, then `rd` @0x0021 → `err`=1 in each cycle, `stall`=0, no `rd_valid`, `busy` unchanged.
- Reset one cycle after a read is accepted → no `rd_valid` after reset. `busy`=0 in the first post-reset cycle.
